id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Parametrised successor of the MIPS decode stage.
- Decodes the instruction from IF/ID and reads a 2R1W register file with write-back bypass.
- Owns the ID/EX pipeline register, with a valid/ready handshake, flush, and load-use hazard stall (one-bubble insertion).
- Sits between the IF/ID register and EX.

Parameters:
- DATA_W, 32, register/datapath width (imm sign/zero-extended to DATA_W).
- NREG, 32, architectural register count; ADDR_W = $clog2(NREG), fixed at 5 for the MIPS encoding.
- LINK_REG, 31, destination index for JAL.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  ID accepts the instruction this cycle
- ins  in  32  instruction word
- npc_i  in  32  PC+4 of ins
- flush  in  1  kill ID/EX contents and the incoming instruction (branch redirect)
- wb_we  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data
- out_valid  out  1  ID/EX holds a valid instruction
- out_ready  in  1  EX consumes ID/EX this cycle
- out_op, out_func  out  6 each  opcode/funct
- out_rs_data, out_rt_data  out  DATA_W  operands
- out_imm  out  DATA_W  extended immediate
- out_jpc  out  26  jump target field
- out_dest  out  ADDR_W  destination register
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control
- out_npc  out  32  passed PC+4

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, all out_* control bits=0, out_dest/out_op/out_func/out_imm/out_jpc/out_npc/out_rs_data/out_rt_data=0.
- Decode is combinational from ins; all outputs are registered, so ID latency is 1 cycle.
- R-type 000000: reg_write=1, dest=ins[15:11].
- ADDI 001000, ADDIU 001001: reg_write=1, dest=rt, sign-extend.
- ANDI 001100, ORI 001101: reg_write=1, dest=rt, zero-extend.
- LUI 001111: reg_write=1, dest=rt, imm={ins[15:0],16'b0}.
- LW 100011, LB 100000: reg_write=1, mem_read=1, dest=rt, sign-extend.
- SW 101011, SB 101000: mem_write=1, sign-extend.
- BEQ 000100, BNE 000101, BGTZ 000111: branch=1, sign-extend.
- J 000010: jump=1.
- JAL 000011: jump=1, reg_write=1, dest=LINK_REG.
- Any other opcode: illegal=1, all other control bits 0, dest=0.
- dest=0 forces reg_write=0 in the registered output.
- Register file: r0 reads 0 and is never written. Write at posedge when wb_we and wb_addr!=0.
- Read bypass: when wb_we and wb_addr==src and src!=0, the operand is wb_data in the same cycle.
- Hazard: hazard = out_valid & out_mem_read & in_valid & out_dest!=0 & (out_dest==rs | (out_dest==rt & ins uses rt)).
  - rt is used by R-type, branches BEQ/BNE, and stores.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Per-cycle priority, evaluated in this order:
  1. flush: out_valid<=0 and the incoming instruction is dropped.
  2. in_valid & in_ready: ID/EX loads the decoded instruction and out_valid<=1.
  3. out_ready: out_valid<=0. If hazard, this is the bubble; the instruction is retried next cycle.
  4. Otherwise ID/EX holds.
- A register-file write occurs regardless of flush or stall.
- Reset mid-stall: the pipeline register clears and register-file contents are untouched, unless REGFILE_CLEAR_EN is defined.

Optional Feature:
- Macro: REGFILE_CLEAR_EN.
- Defined: all NREG registers clear to 0 on reset.
- Undefined: register file has no reset (RAM-inferable) and only r0 reads 0.

Decomposition:
- Package id_pkg:
  - opcode localparams (OP_RTYPE, OP_ADDI, …, OP_JAL);
  - ext_mode enum {EXT_SIGN, EXT_ZERO, EXT_UPPER};
  - packed ctrl_t struct {reg_write, mem_read, mem_write, branch, jump, illegal}.
- Sub-module regfile_2r1w (parameters DATA_W, NREG): register file plus write-first bypass.
- Decode, hazard logic and the ID/EX register stay in id_stage_pipe.

Test Plan:
- Reset, then ADDI r8,r0,-1 (0x2008FFFF) with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_dest=8, out_reg_write=1.
- wb_we=1, wb_addr=9, wb_data=0x1234 while ins=ADD r10,r9,r9 -> out_rs_data=out_rt_data=0x1234 in the same transfer. wb_addr=0 write -> later read of r0 returns 0.
- LW r5,0(r1) accepted, then ADD r6,r5,r2 presented -> in_ready=0 for 1 cycle, out_valid=0 bubble, ADD accepted the cycle after.
- out_ready=0 for 3 cycles with ID/EX valid -> outputs stable, in_ready=0. out_ready=1 -> next instruction loads.
- flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, instruction not accepted; a wb write in the same cycle still lands.
- ORI 0x3402F0F0 -> out_imm=0x0000F0F0. LUI 0x3C02ABCD -> out_imm=0xABCD0000. Opcode 0x3F -> out_illegal=1, out_reg_write=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, extend modes, control bundle.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_UPPER
  } ext_mode_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// 2R1W register file with write-first bypass; r0 is hardwired to zero.
// REGFILE_CLEAR_EN: when defined, every register clears on reset.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

`ifdef REGFILE_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end
`else
  logic rst_unused;
  assign rst_unused = rst_n;

  // No reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) regs[waddr] <= wdata;
  end
`endif

  assign rdata_a = (ra == '0)               ? '0    :
                   (wr_en && waddr == ra)   ? wdata :
                   regs[ra];
  assign rdata_b = (rb == '0)               ? '0    :
                   (wr_en && waddr == rb)   ? wdata :
                   regs[rb];

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS-style decode stage: decode, register read, load-use stall, ID/EX register.
// REGFILE_CLEAR_EN: when defined, the register file clears on reset.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int LINK_REG = 31,
  localparam int ADDR_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ins,
  input  logic [31:0]       npc_i,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_op,
  output logic [5:0]        out_func,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [25:0]       out_jpc,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_illegal,
  output logic [31:0]       out_npc
);

  logic [5:0]        op;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [15:0]       imm16;

  assign op    = ins[31:26];
  assign rs    = ADDR_W'(ins[25:21]);
  assign rt    = ADDR_W'(ins[20:16]);
  assign rd    = ADDR_W'(ins[15:11]);
  assign imm16 = ins[15:0];

  ctrl_t             ctrl_d;
  ext_mode_t         ext_d;
  logic [ADDR_W-1:0] dest_d;
  logic              uses_rt;

  always_comb begin
    ctrl_d  = '0;
    ext_d   = EXT_SIGN;
    dest_d  = '0;
    uses_rt = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        dest_d           = rd;
        uses_rt          = 1'b1;
      end
      op == OP_ADDI, op == OP_ADDIU: begin
        ctrl_d.reg_write = 1'b1;
        dest_d           = rt;
      end
      op == OP_ANDI, op == OP_ORI: begin
        ctrl_d.reg_write = 1'b1;
        dest_d           = rt;
        ext_d            = EXT_ZERO;
      end
      op == OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        dest_d           = rt;
        ext_d            = EXT_UPPER;
      end
      op == OP_LW, op == OP_LB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        dest_d           = rt;
      end
      op == OP_SW, op == OP_SB: begin
        ctrl_d.mem_write = 1'b1;
        uses_rt          = 1'b1;
      end
      op == OP_BEQ, op == OP_BNE: begin
        ctrl_d.branch = 1'b1;
        uses_rt       = 1'b1;
      end
      op == OP_BGTZ: ctrl_d.branch = 1'b1;
      op == OP_J:    ctrl_d.jump   = 1'b1;
      op == OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        dest_d           = ADDR_W'(LINK_REG);
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally dropped.
    if (dest_d == '0) ctrl_d.reg_write = 1'b0;
  end

  logic [DATA_W-1:0] imm_d;

  always_comb begin
    imm_d = {{(DATA_W-16){imm16[15]}}, imm16};
    unique case (ext_d)
      EXT_ZERO:  imm_d = {{(DATA_W-16){1'b0}}, imm16};
      EXT_UPPER: imm_d = DATA_W'({imm16, 16'h0000});
      default:   imm_d = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
  end

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra      (rs),
    .rb      (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  ctrl_t ctrl_q;
  logic  hazard;

  assign hazard = out_valid && ctrl_q.mem_read && in_valid &&
                  (out_dest != '0) &&
                  (out_dest == rs || (out_dest == rt && uses_rt));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      ctrl_q      <= '0;
      out_op      <= '0;
      out_func    <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_jpc     <= '0;
      out_dest    <= '0;
      out_npc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid   <= 1'b1;
      ctrl_q      <= ctrl_d;
      out_op      <= op;
      out_func    <= ins[5:0];
      out_rs_data <= rs_data;
      out_rt_data <= rt_data;
      out_imm     <= imm_d;
      out_jpc     <= ins[25:0];
      out_dest    <= dest_d;
      out_npc     <= npc_i;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_reg_write = ctrl_q.reg_write;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_branch    = ctrl_q.branch;
  assign out_jump      = ctrl_q.jump;
  assign out_illegal   = ctrl_q.illegal;

endmodule
